// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing sequencer: data width, ALU op codes, FSM states.
package alu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/ALU_unit.sv
// Combinational 32-bit ALU; unknown op codes yield result 0 with zero set.
module ALU_unit
  import alu_pkg::*;
(
  input  logic [3:0]      ALU_control,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic [XLEN-1:0] ALU_Result,
  output logic            zero
);

  logic [4:0] shamt;
  assign shamt = B[4:0];

  always_comb begin
    ALU_Result = '0;
    case (ALU_control)
      ALU_AND: ALU_Result = A & B;
      ALU_OR:  ALU_Result = A | B;
      ALU_ADD: ALU_Result = A + B;
      ALU_XOR: ALU_Result = A ^ B;
      ALU_SLT: ALU_Result = {{(XLEN-1){1'b0}}, (A < B)};
      ALU_SLL: ALU_Result = A << shamt;
      ALU_SUB: ALU_Result = A - B;
      ALU_SRL: ALU_Result = A >> shamt;
      ALU_SRA: ALU_Result = XLEN'($signed(A) >>> shamt);
      default: ALU_Result = '0;
    endcase
    zero = (ALU_Result == '0);
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer sharing one ALU_unit between two valid/ready requesters.
// One operation in flight: accept (IDLE) -> compute (EXEC) -> hold result until taken (RESP).
module alu_share_arbiter #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [7:0]        req_op,
  input  logic [2*XLEN-1:0] req_a,
  input  logic [2*XLEN-1:0] req_b,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [XLEN-1:0]   rsp_result,
  output logic              rsp_zero,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_done
);

  import alu_pkg::*;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic [3:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  ops_done_q, ops_done_d;

  logic              grant_c;
  logic [XLEN-1:0]   alu_result;
  logic              alu_zero;

  ALU_unit u_alu (
    .ALU_control (op_q),
    .A           (a_q),
    .B           (b_q),
    .ALU_Result  (alu_result),
    .zero        (alu_zero)
  );

  // On a tie, favour the requester that did not win last time.
  always_comb begin
    grant_c = req_valid[1];
    if (req_valid == 2'b11) begin
      grant_c = ~last_grant_q;
    end
  end

  assign req_ready = ((state_q == ST_IDLE) && (req_valid != 2'b00)) ? (2'b01 << grant_c) : 2'b00;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    zero_d       = zero_q;
    rsp_valid_d  = rsp_valid_q;
    ops_done_d   = ops_done_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid != 2'b00) begin
          state_d      = ST_EXEC;
          owner_d      = grant_c;
          last_grant_d = grant_c;
          op_d         = grant_c ? req_op[7:4] : req_op[3:0];
          a_d          = grant_c ? req_a[2*XLEN-1:XLEN] : req_a[XLEN-1:0];
          b_d          = grant_c ? req_b[2*XLEN-1:XLEN] : req_b[XLEN-1:0];
        end
      end
      ST_EXEC: begin
        state_d     = ST_RESP;
        result_d    = alu_result;
        zero_d      = alu_zero;
        rsp_valid_d = 2'b01 << owner_q;
      end
      ST_RESP: begin
        if (rsp_ready[owner_q]) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 2'b00;
          ops_done_d  = ops_done_q + CNT_W'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 2'b00;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      rsp_valid_q  <= 2'b00;
      busy_q       <= 1'b0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
      ops_done_q   <= ops_done_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign busy       = busy_q;
  assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: transaction-level model predicts grants and results,
// a separate monitor checks every response cycle against the queued expectations.
`timescale 1ns/1ps
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [7:0]       req_op;
  logic [63:0]      req_a;
  logic [63:0]      req_b;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_zero;
  logic             busy;
  logic [CNT_W-1:0] ops_done;

  always #5 clk = ~clk;

  alu_share_arbiter #(.XLEN(32), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .busy       (busy),
    .ops_done   (ops_done)
  );

  typedef struct {
    logic        owner;
    logic [31:0] res;
    logic        zero;
    int unsigned acc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  int unsigned exp_ops = 0;

  logic        pend_v[2];
  logic [3:0]  pend_op[2];
  logic [31:0] pend_a[2];
  logic [31:0] pend_b[2];
  logic        last_g;
  logic [1:0]  rr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference ALU from the op-code table; returns {zero, result}.
  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int unsigned sh;
    sh = int'(b[4:0]);
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0011: r = a ^ b;
      4'b0100: r = (a < b) ? 32'd1 : 32'd0;
      4'b0101: r = a << sh;
      4'b0110: r = a - b;
      4'b1001: r = a >> sh;
      4'b1010: begin
        r = a >> sh;
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
      end
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    pend_v[i]  = 1'b1;
    pend_op[i] = op;
    pend_a[i]  = a;
    pend_b[i]  = b;
  endtask

  // One clock: drive inputs, then check req_ready against the arbitration model.
  task automatic run_cycle(input logic rst);
    logic [1:0]  v;
    logic [1:0]  exp_rdy;
    logic        g;
    logic [32:0] r;
    @(posedge clk);
    #1;
    reset     = rst;
    v         = {pend_v[1], pend_v[0]};
    req_valid = v;
    req_op    = {pend_op[1], pend_op[0]};
    req_a     = {pend_a[1], pend_a[0]};
    req_b     = {pend_b[1], pend_b[0]};
    rsp_ready = rr;
    #2;
    if (rst) begin
      last_g = 1'b1;
      return;
    end
    exp_rdy = 2'b00;
    g = 1'b0;
    if (sb.size() == 0 && v != 2'b00) begin
      g = (v == 2'b11) ? ~last_g : v[1];
      exp_rdy = g ? 2'b10 : 2'b01;
    end
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (exp_rdy != 2'b00) begin
      r = ref_alu(pend_op[g], pend_a[g], pend_b[g]);
      sb.push_back('{owner: g, res: r[31:0], zero: r[32], acc: cyc});
      last_g = g;
      pend_v[g] = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((pend_v[0] || pend_v[1] || sb.size() != 0) && n < 100) begin
      run_cycle(1'b0);
      n++;
    end
    chk("idle_timeout", 32'(n >= 100), 32'd0);
  endtask

  // Monitor: compare the response side every cycle against the scoreboard head.
  initial begin
    logic [1:0] ev;
    forever begin
      @(posedge clk);
      #6;
      if (reset) begin
        sb.delete();
        exp_ops = 0;
        continue;
      end
      chk("ops_done", 32'(ops_done), exp_ops % (1 << CNT_W));
      if (sb.size() != 0 && cyc >= sb[0].acc + 2) begin
        ev = sb[0].owner ? 2'b10 : 2'b01;
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        chk("rsp_result", rsp_result, sb[0].res);
        chk("rsp_zero", 32'(rsp_zero), 32'(sb[0].zero));
        chk("busy_resp", 32'(busy), 32'd1);
        if (rsp_ready[sb[0].owner]) begin
          void'(sb.pop_front());
          exp_ops++;
        end
      end else begin
        chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
        if (sb.size() != 0) chk("busy", 32'(busy), 32'(cyc > sb[0].acc));
        else                chk("busy", 32'(busy), 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rst;
    reset = 1'b1; req_valid = 2'b00; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      pend_v[i] = 1'b0; pend_op[i] = '0; pend_a[i] = '0; pend_b[i] = '0;
    end
    last_g = 1'b1;
    rr = 2'b11;
    run_cycle(1'b1);
    run_cycle(1'b1);
    run_cycle(1'b0);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_zero", 32'(rsp_zero), 32'd0);

    set_req(0, ALU_ADD, 32'h0000_0005, 32'h0000_0007);
    wait_idle();

    set_req(0, ALU_SUB, 32'd9, 32'd9);
    set_req(1, ALU_XOR, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    wait_idle();
    set_req(0, ALU_AND, $urandom, $urandom);
    set_req(1, ALU_OR, $urandom, $urandom);
    wait_idle();

    // Backpressure on r1's response while r0 waits.
    rr = 2'b01;
    set_req(1, ALU_ADD, $urandom, $urandom);
    run_cycle(1'b0);
    set_req(0, ALU_OR, 32'h1234_0000, 32'h0000_5678);
    for (int i = 0; i < 7; i++) run_cycle(1'b0);
    rr = 2'b11;
    wait_idle();

    set_req(0, ALU_SRA, 32'h8000_0000, 32'h0000_0021);
    wait_idle();
    set_req(1, ALU_SLL, 32'd1, 32'd31);
    wait_idle();
    set_req(0, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    wait_idle();
    set_req(1, 4'b0111, $urandom, $urandom);
    wait_idle();
    set_req(0, ALU_SRL, 32'h8000_0000, 32'd4);
    wait_idle();

    // Reset while the accepted op is in EXEC.
    set_req(0, ALU_ADD, 32'd1, 32'd2);
    run_cycle(1'b0);
    run_cycle(1'b1);
    set_req(0, ALU_SUB, 32'd3, 32'd1);
    set_req(1, ALU_ADD, 32'd3, 32'd1);
    wait_idle();

    // Counter wrap: 17 completions from a fresh reset.
    run_cycle(1'b1);
    for (int k = 0; k < 17; k++) begin
      set_req(k % 2, ALU_ADD, $urandom, $urandom);
      wait_idle();
    end
    chk("ops_done_wrap", 32'(ops_done), 32'd1);

    for (int it = 0; it < 600; it++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend_v[i] && $urandom_range(0, 2) == 0) begin
          rb = $urandom;
          ra = ($urandom_range(0, 3) == 0) ? rb : $urandom;
          set_req(i, 4'($urandom_range(0, 15)), ra, rb);
        end
      end
      rr  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      rst = ($urandom_range(0, 99) == 0);
      run_cycle(rst);
    end
    rr = 2'b11;
    wait_idle();
    run_cycle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
